sdram_req_arbiter: RTL and testbench

Multi-port front end for the SDRAM memory controller. It shares the controller's single-word read/write command interface among NUM_PORTS requesters using round-robin arbitration and sequences each transaction through the controller's RDY handshake. It returns read data and a completion pulse to the owning port. A watchdog aborts transactions when the controller stops responding.

---
 rtl/sdram_arb_pkg.sv | 36 +++
 rtl/sdram_req_arbiter_if.sv | 39 +++
 rtl/sdram_rr_pick.sv | 26 ++
 rtl/sdram_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_sdram_req_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM request arbiter.
// Holds the FSM encoding, default sizes and the round-robin search.
package sdram_arb_pkg;

    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_ADDR_W    = 24;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_TIMEOUT   = 1024;
    localparam int MAX_PORTS     = 8;
    localparam int RR_IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    // First requester after 'last', wrapping at n; lowest offset wins.
    function automatic logic [RR_IDX_W-1:0] rr_search(
        input logic [MAX_PORTS-1:0] req,
        input logic [RR_IDX_W-1:0]  last,
        input int                   n
    );
        logic [RR_IDX_W-1:0] idx;
        int p;
        idx = last;
        for (int k = MAX_PORTS; k >= 1; k--) begin
            p = (int'(last) + k) % n;
            if (k <= n && req[p[RR_IDX_W-1:0]])
                idx = p[RR_IDX_W-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// Requester-side and controller-side signals of the arbiter.
// master: the arbiter itself; slave: requesters plus controller.
interface sdram_req_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
);
    logic [NUM_PORTS-1:0]        REQ;
    logic [NUM_PORTS-1:0]        REQ_WE;
    logic [NUM_PORTS*ADDR_W-1:0] REQ_ADR;
    logic [NUM_PORTS*DATA_W-1:0] REQ_WDATA;
    logic [NUM_PORTS-1:0]        ACK;
    logic                        ERR;
    logic [DATA_W-1:0]           RDATA;
    logic [NUM_PORTS-1:0]        GNT;
    logic [ADDR_W-1:0]           MC_ADR_IN;
    logic [DATA_W-1:0]           MC_DIN;
    logic [DATA_W-1:0]           MC_DOUT;
    logic                        MC_RE_IN;
    logic                        MC_WE_IN;
    logic                        MC_RDY;

    modport master (
        input  REQ, REQ_WE, REQ_ADR, REQ_WDATA,
        input  MC_DOUT, MC_RDY,
        output ACK, ERR, RDATA, GNT,
        output MC_ADR_IN, MC_DIN, MC_RE_IN, MC_WE_IN
    );

    modport slave (
        output REQ, REQ_WE, REQ_ADR, REQ_WDATA,
        output MC_DOUT, MC_RDY,
        input  ACK, ERR, RDATA, GNT,
        input  MC_ADR_IN, MC_DIN, MC_RE_IN, MC_WE_IN
    );

endinterface

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin selector.
// Search begins one past the last granted port.
module sdram_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last,
    output logic                 o_vld,
    output logic [IDX_W-1:0]     o_idx
);
    logic [MAX_PORTS-1:0] w_req;
    logic [RR_IDX_W-1:0]  w_idx;

    always_comb begin
        w_req = '0;
        w_req[NUM_PORTS-1:0] = i_req;
    end

    assign w_idx = rr_search(w_req, RR_IDX_W'(i_last), NUM_PORTS);
    assign o_idx = w_idx[IDX_W-1:0];
    assign o_vld = |i_req;

endmodule

// File: rtl/sdram_req_arbiter.sv
// Round-robin multi-port front end for the single-word SDRAM
// controller, with a per-phase watchdog on the RDY handshake.
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                CLK,
    input  logic                RST,
    sdram_req_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_last;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_adr;
    logic [DATA_W-1:0]    r_din;
    logic [DATA_W-1:0]    r_rdata;
    logic [NUM_PORTS-1:0] r_ack;
    logic [NUM_PORTS-1:0] r_gnt;
    logic                 r_err;
    logic [CNT_W-1:0]     r_cnt;

    logic             w_pick_vld;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_grant;
    logic             w_strobe;
    logic             w_done;
    logic             w_tmo;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_cnt_last;

    sdram_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .i_req  (bus.REQ),
        .i_last (r_last),
        .o_vld  (w_pick_vld),
        .o_idx  (w_pick_idx)
    );

    assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_strobe    = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        unique case (r_state)
            // No new grant while ACK is out, so a held REQ is not served twice.
            IDLE: begin
                if (w_pick_vld && !(|r_ack)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.MC_RDY) begin
                    w_strobe    = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!bus.MC_RDY) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = WAIT_DONE;
                end else begin
                    w_cnt_inc = 1'b1;
                    if (w_cnt_last) begin
                        w_tmo       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.MC_RDY) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                    if (w_cnt_last) begin
                        w_tmo       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= IDX_W'(NUM_PORTS - 1);
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_din   <= '0;
            r_rdata <= '0;
            r_ack   <= '0;
            r_gnt   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= '0;
            r_err   <= 1'b0;
            if (w_grant) begin
                r_owner <= w_pick_idx;
                r_we    <= bus.REQ_WE[w_pick_idx];
                r_adr   <= bus.REQ_ADR[int'(w_pick_idx)*ADDR_W +: ADDR_W];
                r_din   <= bus.REQ_WDATA[int'(w_pick_idx)*DATA_W +: DATA_W];
                r_gnt   <= NUM_PORTS'(1) << w_pick_idx;
            end
            if (w_done || w_tmo) begin
                r_ack  <= NUM_PORTS'(1) << r_owner;
                r_err  <= w_tmo;
                r_gnt  <= '0;
                r_last <= r_owner;
            end
            if (w_done && !r_we)
                r_rdata <= bus.MC_DOUT;
            if (w_cnt_clr)
                r_cnt <= '0;
            else if (w_cnt_inc && r_cnt != CNT_W'(TIMEOUT))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.ACK       = r_ack;
    assign bus.ERR       = r_err;
    assign bus.RDATA     = r_rdata;
    assign bus.GNT       = r_gnt;
    assign bus.MC_ADR_IN = r_adr;
    assign bus.MC_DIN    = r_din;
    assign bus.MC_RE_IN  = w_strobe & ~r_we;
    assign bus.MC_WE_IN  = w_strobe & r_we;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter with a simple controller model
// that drops RDY for a programmable number of cycles after a strobe.
module tb_sdram_req_arbiter;
    import sdram_arb_pkg::*;

    localparam int NP = 4;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdram_req_arbiter_if #(
        .NUM_PORTS (NP), .ADDR_W (AW), .DATA_W (DW)
    ) bus ();

    sdram_req_arbiter #(
        .NUM_PORTS (NP), .ADDR_W (AW), .DATA_W (DW), .TIMEOUT (TO)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        int          port;
        bit          we;
        logic [23:0] adr;
        logic [15:0] wd;
        logic [15:0] dout;
        int          busy;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    int errors = 0;
    int checks = 0;

    // monitor state
    int          cyc = 0;
    int          re_cnt = 0, we_cnt = 0, re_cyc = 0, we_cyc = 0;
    int          ack_cnt = 0, ack_cyc = 0;
    logic [3:0]  ack_vec;
    logic        ack_err;
    logic [15:0] ack_rdata;
    logic [23:0] ack_adr;
    logic [15:0] ack_din;
    logic [3:0]  prev_gnt = '0;
    int          ack_q[$], ackc_q[$], gnt_q[$], gntc_q[$];

    // controller model knobs
    int          mc_busy = 2;
    bit          mc_hang = 1'b0;
    logic [15:0] mc_dout = '0;

    function automatic int oh2i(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++)
            if (v[i]) r = i;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int p, input bit we,
                           input logic [23:0] adr,
                           input logic [15:0] wd);
        bus.REQ_WE[p]            = we;
        bus.REQ_ADR[p*AW +: AW]  = adr;
        bus.REQ_WDATA[p*DW +: DW] = wd;
        bus.REQ[p]               = 1'b1;
    endtask

    task automatic wait_ack(input int base, input int budget);
        for (int i = 0; i < budget && ack_cnt == base; i++) tick();
        check("ack_seen", 32'(ack_cnt != base), 1);
    endtask

    task automatic wait_gnt(input int base, input int budget);
        for (int i = 0; i < budget && gnt_q.size() == base; i++) tick();
        check("gnt_seen", 32'(gnt_q.size() != base), 1);
    endtask

    task automatic run(input vec_t v, input bit hang,
                       input bit exp_err, input int exp_lat);
        int b_ack, b_re, b_we;
        b_ack   = ack_cnt;
        b_re    = re_cnt;
        b_we    = we_cnt;
        mc_hang = hang;
        mc_busy = v.busy;
        mc_dout = v.dout;
        set_req(v.port, v.we, v.adr, v.wd);
        wait_ack(b_ack, 100);
        bus.REQ[v.port] = 1'b0;
        repeat (3) tick();
        check("ack_once", ack_cnt - b_ack, 1);
        check("ack_port", ack_vec, 4'b1 << v.port);
        check("err", ack_err, exp_err);
        check("rdata", ack_rdata, v.exp_rdata);
        check("re_strobes", re_cnt - b_re, v.we ? 0 : 1);
        check("we_strobes", we_cnt - b_we, v.we ? 1 : 0);
        check("latency", ack_cyc - (v.we ? we_cyc : re_cyc), exp_lat);
        check("mc_adr", ack_adr, v.adr);
        if (v.we) check("mc_din", ack_din, v.wd);
        mc_hang = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"}, bus.ACK, 0);
        check({tag, "_err"}, bus.ERR, 0);
        check({tag, "_gnt"}, bus.GNT, 0);
        check({tag, "_strb"}, {bus.MC_RE_IN, bus.MC_WE_IN}, 0);
        check({tag, "_rdata"}, bus.RDATA, 0);
        check({tag, "_adr"}, bus.MC_ADR_IN, 0);
        check({tag, "_din"}, bus.MC_DIN, 0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (bus.MC_RE_IN) begin re_cnt++; re_cyc = cyc; end
                if (bus.MC_WE_IN) begin we_cnt++; we_cyc = cyc; end
                if (|bus.ACK) begin
                    ack_cnt++;
                    ack_cyc   = cyc;
                    ack_vec   = bus.ACK;
                    ack_err   = bus.ERR;
                    ack_rdata = bus.RDATA;
                    ack_adr   = bus.MC_ADR_IN;
                    ack_din   = bus.MC_DIN;
                    ack_q.push_back(oh2i(bus.ACK));
                    ackc_q.push_back(cyc);
                end
                if (|bus.GNT && prev_gnt == 0) begin
                    gnt_q.push_back(oh2i(bus.GNT));
                    gntc_q.push_back(cyc);
                end
                prev_gnt = bus.GNT;
            end else begin
                prev_gnt = '0;
            end
        end
    end

    initial begin : mc_model
        forever begin
            @(negedge clk);
            if (!rst && (bus.MC_RE_IN || bus.MC_WE_IN) && !mc_hang) begin
                @(posedge clk);
                #1 bus.MC_RDY = 1'b0;
                repeat (mc_busy) @(posedge clk);
                #1;
                bus.MC_RDY  = 1'b1;
                bus.MC_DOUT = mc_dout;
            end
        end
    end

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin : main
        int exp_ord[6];
        int b, gq;
        vec_t tv;

        vecs[0] = '{2, 1'b0, 24'h000123, 16'h0000, 16'hBEEF, 4, 16'hBEEF};
        vecs[1] = '{1, 1'b1, 24'h00ABCD, 16'h1234, 16'h5555, 2, 16'hBEEF};
        vecs[2] = '{0, 1'b0, 24'hFFFFFF, 16'h0000, 16'h0000, 1, 16'h0000};
        vecs[3] = '{3, 1'b0, 24'h800000, 16'h0000, 16'hFFFF, 7, 16'hFFFF};
        vecs[4] = '{3, 1'b1, 24'h000001, 16'hA5A5, 16'h0000, 3, 16'hFFFF};
        exp_ord = '{0, 1, 2, 3, 0, 1};

        rst           = 1'b1;
        bus.REQ       = '0;
        bus.REQ_WE    = '0;
        bus.REQ_ADR   = '0;
        bus.REQ_WDATA = '0;
        bus.MC_RDY    = 1'b1;
        bus.MC_DOUT   = '0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            run(vecs[i], 1'b0, 1'b0, vecs[i].busy + 2);

        // all ports hold REQ; last grant was port 3
        ack_q.delete(); ackc_q.delete();
        gnt_q.delete(); gntc_q.delete();
        mc_busy = 1;
        mc_dout = 16'h2222;
        for (int p = 0; p < NP; p++)
            set_req(p, 1'b0, 24'(p * 16), 16'h0);
        for (int i = 0; i < 300 && ack_q.size() < 6; i++) tick();
        bus.REQ = '0;
        repeat (6) tick();
        check("rr_acks", ack_q.size(), 6);
        check("rr_gnts", gnt_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check("rr_order", ack_q[k], exp_ord[k]);
            check("rr_gnt_order", gnt_q[k], exp_ord[k]);
        end
        for (int k = 0; k < 5; k++)
            check("rr_gap", gntc_q[k + 1] - ackc_q[k], 2);

        // write held in ISSUE by RDY low for 10 cycles
        b          = we_cnt;
        gq         = gnt_q.size();
        mc_busy    = 3;
        bus.MC_RDY = 1'b0;
        set_req(1, 1'b1, 24'h00BEEF, 16'hC0DE);
        wait_gnt(gq, 20);
        repeat (9) tick();
        bus.MC_RDY = 1'b1;
        wait_ack(ack_cnt, 50);
        bus.REQ[1] = 1'b0;
        repeat (3) tick();
        check("stall_we_cnt", we_cnt - b, 1);
        check("stall_we_cyc", we_cyc - gntc_q[gq], 10);
        check("stall_din", ack_din, 16'hC0DE);
        check("stall_din_hold", bus.MC_DIN, 16'hC0DE);
        check("stall_ack", ack_vec, 4'b0010);

        // watchdog: controller never drops RDY
        tv = '{0, 1'b0, 24'h000777, 16'h0, 16'h1111, 0, 16'h2222};
        run(tv, 1'b1, 1'b1, TO + 1);
        tv = '{2, 1'b0, 24'h000042, 16'h0, 16'h3333, 2, 16'h3333};
        run(tv, 1'b0, 1'b0, 4);

        // port 3 withdraws REQ right after its grant
        b       = ack_cnt;
        gq      = gnt_q.size();
        mc_busy = 2;
        mc_dout = 16'h7777;
        set_req(3, 1'b0, 24'h0003A0, 16'h0);
        wait_gnt(gq, 20);
        bus.REQ[3] = 1'b0;
        wait_ack(b, 50);
        repeat (5) tick();
        check("drop_ack", ack_vec, 4'b1000);
        check("drop_ack_cnt", ack_cnt - b, 1);
        check("drop_gnt_cnt", gnt_q.size() - gq, 1);
        check("drop_rdata", ack_rdata, 16'h7777);
        check("drop_adr_hold", bus.MC_ADR_IN, 24'h0003A0);

        // reset mid-WAIT_DONE, port 0 last served before it
        tv = '{0, 1'b0, 24'h000010, 16'h0, 16'h4444, 1, 16'h4444};
        run(tv, 1'b0, 1'b0, 3);
        b       = re_cnt;
        mc_busy = 8;
        set_req(1, 1'b0, 24'h000020, 16'h0);
        for (int i = 0; i < 20 && re_cnt == b; i++) tick();
        repeat (3) tick();
        check("pre_rst_gnt", bus.GNT, 4'b0010);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        bus.REQ = '0;
        repeat (12) tick();
        rst = 1'b0;
        tick();
        mc_busy = 1;
        mc_dout = 16'h5555;
        set_req(0, 1'b0, 24'h000050, 16'h0);
        set_req(1, 1'b0, 24'h000060, 16'h0);
        wait_ack(ack_cnt, 50);
        bus.REQ[0] = 1'b0;
        check("post_rst_first", ack_vec, 4'b0001);
        check("post_rst_rdata", ack_rdata, 16'h5555);
        wait_ack(ack_cnt, 50);
        bus.REQ[1] = 1'b0;
        check("post_rst_second", ack_vec, 4'b0010);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
